// File: rtl/fsc_framer_pkg.sv
// fsc_framer_pkg: shared constants and types for the nibble framer.
// Optional FSC_FRAMER_XOR_EN adds a running lane XOR (see collector/top).
package fsc_framer_pkg;
    localparam int LANES = 6;
    localparam int DEF_NIBBLE_W = 4;
    typedef logic [2:0] cnt_t;
    localparam cnt_t LANE_A = 3'd0;
    localparam cnt_t LANE_B = 3'd1;
    localparam cnt_t LANE_C = 3'd2;
    localparam cnt_t LANE_D = 3'd3;
    localparam cnt_t LANE_E = 3'd4;
    localparam cnt_t LANE_G = 3'd5;
endpackage

// File: rtl/fsc_nibble_framer_if.sv
// fsc_nibble_framer_if: nibble input stream and parallel frame output bus.
// FSC_FRAMER_XOR_EN adds the m_oq lane-XOR signal.
interface fsc_nibble_framer_if import fsc_framer_pkg::*; #(parameter int NIBBLE_W = DEF_NIBBLE_W);
    logic [NIBBLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_sof;
    logic                s_ready;
    logic [NIBBLE_W-1:0] m_ia, m_ib, m_ic, m_id, m_ie, m_ig;
    logic                m_valid;
    logic                m_ready;
`ifdef FSC_FRAMER_XOR_EN
    logic [NIBBLE_W-1:0] m_oq;
`endif
    modport master (
`ifdef FSC_FRAMER_XOR_EN
        input  m_oq,
`endif
        output s_data, s_valid, s_sof, m_ready,
        input  s_ready, m_ia, m_ib, m_ic, m_id, m_ie, m_ig, m_valid
    );
    modport slave (
`ifdef FSC_FRAMER_XOR_EN
        output m_oq,
`endif
        input  s_data, s_valid, s_sof, m_ready,
        output s_ready, m_ia, m_ib, m_ic, m_id, m_ie, m_ig, m_valid
    );
endinterface

// File: rtl/fsc_framer_collector.sv
// fsc_framer_collector: gathers accepted nibbles into lanes, handles sof resync and drop count.
// FSC_FRAMER_XOR_EN adds the incremental lane XOR accumulator.
module fsc_framer_collector import fsc_framer_pkg::*; #(
    parameter int NIBBLE_W = DEF_NIBBLE_W,
    parameter int DROP_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            beat,
    input  logic                            sof,
    input  logic [NIBBLE_W-1:0]             data,
    output cnt_t                            cnt,
    output logic                            done,
    output logic [LANES-1:0][NIBBLE_W-1:0]  frame,
`ifdef FSC_FRAMER_XOR_EN
    output logic [NIBBLE_W-1:0]             xq,
`endif
    output logic [DROP_W-1:0]               drop
);
    logic [LANES-2:0][NIBBLE_W-1:0] lane;
    logic abort;
    cnt_t idx;
    assign abort = beat && sof && cnt != LANE_A;
    assign idx = abort ? LANE_A : cnt;
    assign done = beat && idx == LANE_G;
    // the completing beat is lane 5 straight from the input, so only lanes 0..4 are stored
    assign frame = {data, lane};
`ifdef FSC_FRAMER_XOR_EN
    logic [NIBBLE_W-1:0] acc;
    assign xq = (idx == LANE_A ? '0 : acc) ^ data;
    always_ff @(posedge clk)
        if (rst) acc <= '0;
        else if (beat) acc <= xq;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= LANE_A;
            lane <= '0;
            drop <= '0;
        end else if (beat) begin
            if (idx != LANE_G) lane[idx] <= data;
            cnt <= done ? LANE_A : idx + 3'd1;
            if (abort && drop != '1) drop <= drop + 1'b1;
        end
    end
endmodule

// File: rtl/fsc_nibble_framer.sv
// fsc_nibble_framer: six-nibble framer with registered, back-pressured frame output.
// FSC_FRAMER_XOR_EN adds m_oq, the XOR of the six lanes of the output frame.
module fsc_nibble_framer import fsc_framer_pkg::*; #(
    parameter int NIBBLE_W = DEF_NIBBLE_W,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    fsc_nibble_framer_if.slave bus,
    output logic [DROP_W-1:0] o_drop
);
    cnt_t cnt;
    logic done;
    logic [LANES-1:0][NIBBLE_W-1:0] frame;
`ifdef FSC_FRAMER_XOR_EN
    logic [NIBBLE_W-1:0] xq;
`endif
    // stall only when a completing beat would overwrite an undelivered frame
    assign bus.s_ready = !(cnt == LANE_G && bus.m_valid && !bus.m_ready);
    fsc_framer_collector #(.NIBBLE_W(NIBBLE_W), .DROP_W(DROP_W)) u_col (
        .clk   (clk),
        .rst   (rst),
        .beat  (bus.s_valid && bus.s_ready),
        .sof   (bus.s_sof),
        .data  (bus.s_data),
        .cnt   (cnt),
        .done  (done),
        .frame (frame),
`ifdef FSC_FRAMER_XOR_EN
        .xq    (xq),
`endif
        .drop  (o_drop)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            {bus.m_ia, bus.m_ib, bus.m_ic, bus.m_id, bus.m_ie, bus.m_ig} <= '0;
`ifdef FSC_FRAMER_XOR_EN
            bus.m_oq <= '0;
`endif
        end else if (done) begin
            bus.m_valid <= 1'b1;
            bus.m_ia <= frame[LANE_A];
            bus.m_ib <= frame[LANE_B];
            bus.m_ic <= frame[LANE_C];
            bus.m_id <= frame[LANE_D];
            bus.m_ie <= frame[LANE_E];
            bus.m_ig <= frame[LANE_G];
`ifdef FSC_FRAMER_XOR_EN
            bus.m_oq <= xq;
`endif
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fsc_nibble_framer.sv
// tb_fsc_nibble_framer: directed self-checking bench for fsc_nibble_framer.
// Define FSC_FRAMER_XOR_EN on both RTL and bench to also check m_oq.
module tb_fsc_nibble_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] o_drop;
    int checks = 0;
    int failures = 0;
    fsc_nibble_framer_if #(.NIBBLE_W(4)) bus ();
    fsc_nibble_framer #(.NIBBLE_W(4), .DROP_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .o_drop (o_drop)
    );
    always #5 clk = ~clk;
    function automatic logic [23:0] fr();
        return {bus.m_ia, bus.m_ib, bus.m_ic, bus.m_id, bus.m_ie, bus.m_ig};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_oq(input string tag, input logic [3:0] exp);
`ifdef FSC_FRAMER_XOR_EN
        chk(tag, {28'd0, bus.m_oq}, {28'd0, exp});
`else
        if (exp === 4'hx) $display("unused %s", tag);
`endif
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [3:0] d, input logic s);
        bus.s_valid = 1'b1;
        bus.s_data = d;
        bus.s_sof = s;
        tick();
    endtask
    task automatic idle();
        bus.s_valid = 1'b0;
        tick();
    endtask
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 4'h0;
        bus.s_sof = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        tick();
        chk("rst_mvalid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_lanes", {8'd0, fr()}, 32'd0);
        chk("rst_drop", {24'd0, o_drop}, 32'd0);
        chk_oq("rst_oq", 4'h0);
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.s_ready}, 32'd1);
        // basic frame 1..6
        push(4'h1, 1'b1);
        for (int i = 2; i <= 5; i++) push(4'(i), 1'b0);
        chk("basic_early", {31'd0, bus.m_valid}, 32'd0);
        push(4'h6, 1'b0);
        chk("basic_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("basic_frame", {8'd0, fr()}, 32'h123456);
        chk_oq("basic_oq", 4'h7);
        idle();
        chk("basic_drain", {31'd0, bus.m_valid}, 32'd0);
        // two back-to-back frames with continuous s_valid
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = (i < 6) ? 4'(10 + i) : 4'(i - 6);
            bus.s_sof = (i == 0 || i == 6);
            chk("b2b_ready", {31'd0, bus.s_ready}, 32'd1);
            tick();
            if (i == 5) begin
                chk("b2b_f1_valid", {31'd0, bus.m_valid}, 32'd1);
                chk("b2b_f1_frame", {8'd0, fr()}, 32'hABCDEF);
                chk_oq("b2b_f1_oq", 4'h1);
            end
            if (i == 6) chk("b2b_gap", {31'd0, bus.m_valid}, 32'd0);
        end
        chk("b2b_f2_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("b2b_f2_frame", {8'd0, fr()}, 32'h012345);
        chk_oq("b2b_f2_oq", 4'h1);
        idle();
        // back-pressure: frame 1 held, stall on 6th beat of frame 2
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(4'(i), i == 1);
        chk("bp_f1_valid", {31'd0, bus.m_valid}, 32'd1);
        for (int i = 7; i <= 11; i++) push(4'(i), i == 7);
        chk("bp_hold_frame", {8'd0, fr()}, 32'h123456);
        chk("bp_hold_valid", {31'd0, bus.m_valid}, 32'd1);
        bus.s_valid = 1'b1;
        bus.s_data = 4'hC;
        bus.s_sof = 1'b0;
        #1;
        chk("bp_stall", {31'd0, bus.s_ready}, 32'd0);
        tick();
        chk("bp_stall_frame", {8'd0, fr()}, 32'h123456);
        chk("bp_stall_ready", {31'd0, bus.s_ready}, 32'd0);
        bus.m_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.s_ready}, 32'd1);
        tick();
        chk("bp_f2_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("bp_f2_frame", {8'd0, fr()}, 32'h789ABC);
        chk_oq("bp_f2_oq", 4'hB);
        idle();
        chk("bp_drain", {31'd0, bus.m_valid}, 32'd0);
        // sof abort resynchronises
        for (int i = 0; i < 3; i++) push(4'h9, i == 0);
        push(4'hF, 1'b1);
        chk("abort_drop", {24'd0, o_drop}, 32'd1);
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
        chk("abort_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("abort_frame", {8'd0, fr()}, 32'hF12345);
        chk_oq("abort_oq", 4'hE);
        idle();
        // drop counter saturation: first push starts a frame, the rest abort
        for (int i = 0; i < 254; i++) push(4'h0, 1'b1);
        chk("sat_254", {24'd0, o_drop}, 32'd254);
        push(4'h0, 1'b1);
        chk("sat_255", {24'd0, o_drop}, 32'd255);
        push(4'h0, 1'b1);
        push(4'h0, 1'b1);
        chk("sat_hold", {24'd0, o_drop}, 32'd255);
        // reset mid-frame with a pending frame
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(4'(i), i == 1);
        chk("rstmid_pending", {8'd0, fr()}, 32'h123456);
        for (int i = 0; i < 4; i++) push(4'(10 + i), 1'b0);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rstmid_drop", {24'd0, o_drop}, 32'd0);
        chk("rstmid_lanes", {8'd0, fr()}, 32'd0);
        bus.m_ready = 1'b1;
        for (int i = 6; i >= 1; i--) push(4'(i), 1'b0);
        chk("rstmid_clean_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("rstmid_clean_frame", {8'd0, fr()}, 32'h654321);
        chk_oq("rstmid_clean_oq", 4'h7);
        // s_valid toggling with garbage on idle cycles
        for (int i = 9; i >= 4; i--) begin
            bus.s_valid = 1'b0;
            bus.s_data = ~4'(i);
            bus.s_sof = 1'b1;
            tick();
            push(4'(i), 1'b0);
        end
        chk("toggle_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("toggle_frame", {8'd0, fr()}, 32'h987654);
        chk("toggle_drop", {24'd0, o_drop}, 32'd0);
        chk_oq("toggle_oq", 4'h1);
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
